// File: rtl/lcd_pixel_source.sv
// lcd_pixel_source: test-pattern pixel generator for an LCD writer.
// Waits for a rising edge on the panel's tearing-effect (fmark) line, then
// streams one frame column-major (y inner, x outer) under valid/ready flow
// control. Pixel data is decoded combinationally from the scan position, so
// the outputs stay put automatically while the downstream writer stalls.

module lcd_pixel_source #(
    parameter int COLS = 320,
    parameter int ROWS = 240
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic [1:0]  i_pattern,
    input  logic [15:0] i_color,
    input  logic        i_lcd_fmark,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [15:0] o_pixel,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_late,
    output logic [8:0]  o_frame_cnt
);

    // x is at least 9 bits so the bar pattern can always index x[8:6];
    // y is at least 6 bits so the constant 32 is representable for pattern 2.
    localparam int XW = ($clog2(COLS) > 9) ? $clog2(COLS) : 9;
    localparam int YW = ($clog2(ROWS) > 6) ? $clog2(ROWS) : 6;

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [YW-1:0] Y_BAND = YW'(32);
    localparam logic [8:0]    F_LAST = 9'(COLS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_FM = 2'd1;
    localparam logic [1:0] S_STREAM  = 2'd2;

    logic [1:0]    r_state;
    logic          r_fm_meta;
    logic          r_fm_sync;
    logic          r_fm_prev;
    logic [1:0]    r_fm_live;
    logic [1:0]    r_pattern;
    logic [15:0]   r_color;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [8:0]    r_frame_cnt;
    logic          r_late;

    logic          w_fm_rise;
    logic          w_streaming;
    logic          w_last_pix;
    logic [15:0]   w_pattern_pix;

    // Synchronise fmark and track its previous value. The edge detector is
    // held "high" until the synchroniser has been refilled with real samples,
    // so an fmark already high at reset release is not mistaken for an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fm_meta <= 1'b0;
            r_fm_sync <= 1'b0;
            r_fm_live <= 2'b00;
            r_fm_prev <= 1'b1;
        end else begin
            r_fm_meta <= i_lcd_fmark;
            r_fm_sync <= r_fm_meta;
            r_fm_live <= {r_fm_live[0], 1'b1};
            r_fm_prev <= r_fm_live[1] ? r_fm_sync : 1'b1;
        end
    end

    assign w_fm_rise   = r_fm_sync & ~r_fm_prev;
    assign w_streaming = (r_state == S_STREAM);
    assign w_last_pix  = (r_x == X_LAST) && (r_y == Y_LAST);

    // Frame sequencer and scan counters: arm on enable, start on fmark edge,
    // advance one pixel per accepted handshake, return to idle after eof.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_pattern   <= 2'd0;
            r_color     <= 16'h0000;
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= 9'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_state <= S_WAIT_FM;
                    end
                end
                S_WAIT_FM: begin
                    if (!i_enable) begin
                        r_state <= S_IDLE;
                    end else if (w_fm_rise) begin
                        r_state   <= S_STREAM;
                        r_pattern <= i_pattern;
                        r_color   <= i_color;
                        r_x       <= '0;
                        r_y       <= '0;
                    end
                end
                S_STREAM: begin
                    if (i_ready) begin
                        if (w_last_pix) begin
                            r_state     <= S_IDLE;
                            r_frame_cnt <= (r_frame_cnt == F_LAST) ? 9'd0 : r_frame_cnt + 9'd1;
                        end else if (r_y == Y_LAST) begin
                            r_y <= '0;
                            r_x <= r_x + X_ONE;
                        end else begin
                            r_y <= r_y + Y_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Flag an fmark edge that arrives while a frame is still being streamed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_late <= 1'b0;
        end else begin
            r_late <= w_fm_rise && w_streaming;
        end
    end

    // Decode the latched pattern at the current scan position.
    always_comb begin
        w_pattern_pix = 16'h0000;
        case (r_pattern)
            2'd0: w_pattern_pix = r_color;
            2'd1: w_pattern_pix = {{5{r_x[8]}}, {6{r_x[7]}}, {5{r_x[6]}}};
            2'd2: begin
                if (r_y < Y_BAND) begin
                    w_pattern_pix = 16'hF800;
                end else if (r_x == XW'(r_frame_cnt)) begin
                    w_pattern_pix = 16'h07E0;
                end
            end
            default: begin
                if (r_x[4] ^ r_y[4]) begin
                    w_pattern_pix = 16'hFFFF;
                end
            end
        endcase
    end

    assign o_valid     = w_streaming;
    assign o_pixel     = w_streaming ? w_pattern_pix : 16'h0000;
    assign o_sof       = w_streaming && (r_x == '0) && (r_y == '0);
    assign o_eof       = w_streaming && w_last_pix;
    assign o_late      = r_late;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_lcd_pixel_source.sv
// Bench for lcd_pixel_source. Three instances share one clock:
//   dutA - default 320x240, one full frame of a solid colour;
//   dutB - 8x104, a table of frames plus reset / enable corner cases;
//   dutC - 512x2, the eight vertical bars of pattern 1.
module tb_lcd_pixel_source;

    localparam int B_COLS  = 8;
    localparam int B_ROWS  = 104;
    localparam int B_TOTAL = B_COLS * B_ROWS;

    typedef struct {
        logic [1:0]  pattern;
        logic [15:0] color;
        bit          rdyRandom;
        int          lateAt;
        int          dropEnAt;
        int          pAx;
        int          pAy;
        logic [15:0] pAexp;
        int          pBx;
        int          pBy;
        logic [15:0] pBexp;
    } vec_t;

    logic clk = 1'b0;

    logic rstA, enA, fmA, rdyA, voA, sofA, eofA, lateA;
    logic [1:0] patA;
    logic [15:0] colA, pixA;
    logic [8:0] fcntA;

    logic rstB, enB, fmB, rdyB, voB, sofB, eofB, lateB;
    logic [1:0] patB;
    logic [15:0] colB, pixB;
    logic [8:0] fcntB;

    logic rstC, enC, fmC, rdyC, voC, sofC, eofC, lateC;
    logic [1:0] patC;
    logic [15:0] colC, pixC;
    logic [8:0] fcntC;

    int nCompared = 0;
    int nMismatched = 0;
    int frameB = 0;
    vec_t vecs[8];

    lcd_pixel_source dutA (
        .i_clk(clk), .i_rst_n(rstA), .i_enable(enA), .i_pattern(patA), .i_color(colA),
        .i_lcd_fmark(fmA), .i_ready(rdyA), .o_valid(voA), .o_pixel(pixA), .o_sof(sofA),
        .o_eof(eofA), .o_late(lateA), .o_frame_cnt(fcntA)
    );

    lcd_pixel_source #(.COLS(B_COLS), .ROWS(B_ROWS)) dutB (
        .i_clk(clk), .i_rst_n(rstB), .i_enable(enB), .i_pattern(patB), .i_color(colB),
        .i_lcd_fmark(fmB), .i_ready(rdyB), .o_valid(voB), .o_pixel(pixB), .o_sof(sofB),
        .o_eof(eofB), .o_late(lateB), .o_frame_cnt(fcntB)
    );

    lcd_pixel_source #(.COLS(512), .ROWS(2)) dutC (
        .i_clk(clk), .i_rst_n(rstC), .i_enable(enC), .i_pattern(patC), .i_color(colC),
        .i_lcd_fmark(fmC), .i_ready(rdyC), .o_valid(voC), .o_pixel(pixC), .o_sof(sofC),
        .o_eof(eofC), .o_late(lateC), .o_frame_cnt(fcntC)
    );

    // Free-running clock shared by all three instances.
    always #5 clk = ~clk;

    // Hard stop in case some wait never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        nCompared++;
        if (got !== want) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Reference pixel for every pattern at scan position (x, y).
    function automatic logic [15:0] expPixel(input logic [1:0] pat, input logic [15:0] col,
                                             input int frame, input int x, input int y);
        logic [8:0] xb;
        logic [8:0] yb;
        xb = x[8:0];
        yb = y[8:0];
        case (pat)
            2'd0: return col;
            2'd1: return {{5{xb[8]}}, {6{xb[7]}}, {5{xb[6]}}};
            2'd2: begin
                if (y < 32) return 16'hF800;
                else if (x == frame) return 16'h07E0;
                else return 16'h0000;
            end
            default: return (xb[4] ^ yb[4]) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Run one whole frame on dutB, checking every accepted pixel, the
    // sof/eof flags, stall stability, o_late pulses and the frame counter.
    task automatic applyStimulus(input vec_t v, input string tag);
        int acc, cyc, mx, my, firstCyc, lastCyc, lateCnt;
        int pixBad, flagBad, stallBad, gapBad, probeHits, n;
        logic [15:0] holdPix;
        logic holdSof, holdEof, holdPending, rdyNow;
        acc = 0; cyc = 0; mx = 0; my = 0; firstCyc = -1; lastCyc = -1; lateCnt = 0;
        pixBad = 0; flagBad = 0; stallBad = 0; gapBad = 0; probeHits = 0; n = 0;
        holdPix = 16'h0000; holdSof = 1'b0; holdEof = 1'b0; holdPending = 1'b0;
        enB = 1'b1; patB = v.pattern; colB = v.color; rdyB = 1'b0; fmB = 1'b0;
        repeat (4) tick();
        fmB = 1'b1;
        while (acc < B_TOTAL && cyc < 4 * B_TOTAL + 50) begin
            tick();
            cyc++;
            if (cyc == 3) fmB = 1'b0;
            if (v.lateAt > 0 && cyc == v.lateAt) fmB = 1'b1;
            if (v.lateAt > 0 && cyc == v.lateAt + 3) fmB = 1'b0;
            if (v.dropEnAt > 0 && cyc == v.dropEnAt) enB = 1'b0;
            rdyNow = v.rdyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
            rdyB = rdyNow;
            if (lateB === 1'b1) lateCnt++;
            if (holdPending && (voB !== 1'b1 || pixB !== holdPix || sofB !== holdSof || eofB !== holdEof))
                stallBad++;
            holdPending = 1'b0;
            if (voB === 1'b1) begin
                if (firstCyc < 0) begin
                    firstCyc = cyc;
                    patB = ~v.pattern;
                    colB = ~v.color;
                end
                lastCyc = cyc;
                if (sofB !== (mx == 0 && my == 0) || eofB !== (mx == B_COLS - 1 && my == B_ROWS - 1))
                    flagBad++;
                if (rdyNow) begin
                    if (pixB !== expPixel(v.pattern, v.color, frameB, mx, my)) pixBad++;
                    if (mx == v.pAx && my == v.pAy) begin
                        checkOutput({tag, "/probeA"}, pixB, v.pAexp);
                        probeHits++;
                    end
                    if (mx == v.pBx && my == v.pBy) begin
                        checkOutput({tag, "/probeB"}, pixB, v.pBexp);
                        probeHits++;
                    end
                    acc++;
                    if (my == B_ROWS - 1) begin
                        my = 0;
                        mx++;
                    end else begin
                        my++;
                    end
                end else begin
                    holdPending = 1'b1;
                    holdPix = pixB;
                    holdSof = sofB;
                    holdEof = eofB;
                end
            end else if (firstCyc >= 0) begin
                gapBad++;
            end
        end
        checkOutput({tag, "/pixelCount"}, acc, B_TOTAL);
        checkOutput({tag, "/firstLatency"}, firstCyc, 3);
        checkOutput({tag, "/pixelErrors"}, pixBad, 0);
        checkOutput({tag, "/sofEofErrors"}, flagBad, 0);
        checkOutput({tag, "/stallErrors"}, stallBad, 0);
        checkOutput({tag, "/gapErrors"}, gapBad, 0);
        checkOutput({tag, "/latePulses"}, lateCnt, (v.lateAt > 0) ? 1 : 0);
        checkOutput({tag, "/probeHits"}, probeHits, 2);
        if (!v.rdyRandom) checkOutput({tag, "/noBubbles"}, lastCyc - firstCyc + 1, B_TOTAL);
        tick();
        frameB = (frameB == B_COLS - 1) ? 0 : frameB + 1;
        checkOutput({tag, "/validAfterEof"}, voB, 0);
        checkOutput({tag, "/frameCnt"}, fcntB, frameB);
        if (v.dropEnAt > 0) begin
            fmB = 1'b0;
            repeat (4) tick();
            fmB = 1'b1;
            repeat (3) begin
                tick();
                if (voB !== 1'b0) n++;
            end
            fmB = 1'b0;
            repeat (17) begin
                tick();
                if (voB !== 1'b0) n++;
            end
            checkOutput({tag, "/idleAfterEnableDrop"}, n, 0);
        end
    endtask

    // One full default-size frame of solid colour 16'h1234 with ready held high.
    task automatic runFullFrame();
        int cyc, cnt, bad, firstCyc, lastCyc, sofCnt, sofAt, eofCnt, eofAt;
        cyc = 0; cnt = 0; bad = 0; firstCyc = -1; lastCyc = -1;
        sofCnt = 0; sofAt = -1; eofCnt = 0; eofAt = -1;
        enA = 1'b1; patA = 2'd0; colA = 16'h1234; rdyA = 1'b1; fmA = 1'b0;
        repeat (4) tick();
        checkOutput("full/frameCntBefore", fcntA, 0);
        fmA = 1'b1;
        while (cyc < 80000) begin
            tick();
            cyc++;
            if (cyc == 3) fmA = 1'b0;
            if (voA === 1'b1) begin
                cnt++;
                if (firstCyc < 0) firstCyc = cyc;
                lastCyc = cyc;
                if (pixA !== 16'h1234) bad++;
                if (sofA === 1'b1) begin
                    sofCnt++;
                    sofAt = cnt;
                end
                if (eofA === 1'b1) begin
                    eofCnt++;
                    eofAt = cnt;
                end
            end else if (cnt > 0) begin
                break;
            end
        end
        checkOutput("full/pixelCount", cnt, 76800);
        checkOutput("full/consecutive", lastCyc - firstCyc + 1, 76800);
        checkOutput("full/pixelErrors", bad, 0);
        checkOutput("full/sofCount", sofCnt, 1);
        checkOutput("full/sofPosition", sofAt, 1);
        checkOutput("full/eofCount", eofCnt, 1);
        checkOutput("full/eofPosition", eofAt, 76800);
        checkOutput("full/validAfterEof", voA, 0);
        checkOutput("full/frameCntAfter", fcntA, 1);
    endtask

    // Pattern 1 over 512 columns so all eight bars appear.
    task automatic runBars();
        int cyc, acc, bad, eofAt, x, y;
        cyc = 0; acc = 0; bad = 0; eofAt = -1;
        enC = 1'b1; patC = 2'd1; colC = 16'h0000; rdyC = 1'b1; fmC = 1'b0;
        repeat (4) tick();
        fmC = 1'b1;
        while (acc < 1024 && cyc < 1200) begin
            tick();
            cyc++;
            if (cyc == 3) fmC = 1'b0;
            if (voC === 1'b1) begin
                x = acc / 2;
                y = acc % 2;
                if (pixC !== expPixel(2'd1, 16'h0000, 0, x, y)) bad++;
                if (x == 64 && y == 0) checkOutput("bars/x64", pixC, 16'h001F);
                if (x == 128 && y == 1) checkOutput("bars/x128", pixC, 16'h07E0);
                if (x == 320 && y == 0) checkOutput("bars/x320", pixC, 16'hF81F);
                if (x == 448 && y == 1) checkOutput("bars/x448", pixC, 16'hFFFF);
                acc++;
                if (eofC === 1'b1) eofAt = acc;
            end
        end
        checkOutput("bars/pixelCount", acc, 1024);
        checkOutput("bars/pixelErrors", bad, 0);
        checkOutput("bars/eofPosition", eofAt, 1024);
        tick();
        checkOutput("bars/frameCnt", fcntC, 1);
    endtask

    // Table frames on dutB followed by the enable and reset corner cases.
    task automatic runSmall();
        int n;
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        enB = 1'b1; fmB = 1'b0; rdyB = 1'b1; n = 0;
        repeat (3) tick();
        enB = 1'b0;
        repeat (2) tick();
        fmB = 1'b1;
        repeat (3) begin
            tick();
            if (voB !== 1'b0) n++;
        end
        fmB = 1'b0;
        repeat (20) begin
            tick();
            if (voB !== 1'b0) n++;
        end
        checkOutput("waitFmEnableDrop/validCycles", n, 0);

        applyStimulus('{2'd3, 16'h0000, 1'b0, 0, 0, 0, 16, 16'hFFFF, 7, 0, 16'h0000}, "extraFrame");

        enB = 1'b1; patB = 2'd0; colB = 16'hA5A5; rdyB = 1'b1; fmB = 1'b0; n = 0;
        repeat (4) tick();
        fmB = 1'b1;
        while (voB !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        fmB = 1'b0;
        repeat (3 * B_ROWS + 50) tick();
        checkOutput("midReset/validBefore", voB, 1);
        rstB = 1'b0;
        #1;
        checkOutput("midReset/valid", voB, 0);
        checkOutput("midReset/pixel", pixB, 0);
        checkOutput("midReset/sof", sofB, 0);
        checkOutput("midReset/eof", eofB, 0);
        checkOutput("midReset/late", lateB, 0);
        checkOutput("midReset/frameCnt", fcntB, 0);
        fmB = 1'b1;
        repeat (2) tick();
        rstB = 1'b1;
        n = 0;
        repeat (20) begin
            tick();
            if (voB !== 1'b0) n++;
        end
        checkOutput("fmHighAtRelease/validCycles", n, 0);
        frameB = 0;
        applyStimulus('{2'd0, 16'hA5A5, 1'b0, 0, 0, 0, 0, 16'hA5A5, 7, 103, 16'hA5A5}, "afterReset");
    endtask

    // Reset everything, check the reset state, then run the three threads.
    initial begin
        vecs[0] = '{2'd0, 16'hBEEF, 1'b0, 0,   0,   3, 50,  16'hBEEF, 7, 103, 16'hBEEF};
        vecs[1] = '{2'd3, 16'h0000, 1'b0, 0,   0,   0, 16,  16'hFFFF, 0, 15,  16'h0000};
        vecs[2] = '{2'd3, 16'h0000, 1'b1, 0,   0,   1, 31,  16'hFFFF, 2, 32,  16'h0000};
        vecs[3] = '{2'd2, 16'h0000, 1'b0, 300, 0,   3, 40,  16'h07E0, 3, 31,  16'hF800};
        vecs[4] = '{2'd2, 16'h0000, 1'b1, 0,   0,   5, 40,  16'h0000, 4, 33,  16'h07E0};
        vecs[5] = '{2'd2, 16'h0000, 1'b0, 0,   0,   5, 100, 16'h07E0, 5, 10,  16'hF800};
        vecs[6] = '{2'd0, 16'h0001, 1'b1, 0,   200, 0, 0,   16'h0001, 7, 103, 16'h0001};
        vecs[7] = '{2'd1, 16'hFFFF, 1'b0, 0,   0,   0, 0,   16'h0000, 7, 103, 16'h0000};

        rstA = 1'b0; enA = 1'b1; patA = 2'd0; colA = 16'hFFFF; fmA = 1'b0; rdyA = 1'b1;
        rstB = 1'b0; enB = 1'b1; patB = 2'd0; colB = 16'hFFFF; fmB = 1'b0; rdyB = 1'b1;
        rstC = 1'b0; enC = 1'b0; patC = 2'd0; colC = 16'h0000; fmC = 1'b0; rdyC = 1'b0;
        repeat (3) tick();
        checkOutput("reset/valid", voB, 0);
        checkOutput("reset/pixel", pixB, 0);
        checkOutput("reset/sof", sofB, 0);
        checkOutput("reset/eof", eofB, 0);
        checkOutput("reset/late", lateB, 0);
        checkOutput("reset/frameCnt", fcntB, 0);
        checkOutput("reset/validA", voA, 0);
        rstA = 1'b1;
        rstB = 1'b1;
        rstC = 1'b1;
        $display("[TB] reset released, starting frames");
        fork
            runFullFrame();
            runSmall();
            runBars();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
